// File: rtl/if_fetch_queue_pkg.sv
// Shared widths, fetch-address constants and the queued {pc, inst} payload for the fetch front end.
package if_fetch_queue_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;

    localparam logic                   CHIP_ENABLE     = 1'b1;
    localparam logic                   CHIP_DISABLE    = 1'b0;
    localparam logic [INST_W-1:0]      ZERO_WORD       = '0;
    localparam logic [INST_ADDR_W-1:0] START_INST_ADDR = 32'h0000_0000;
    localparam logic [INST_ADDR_W-1:0] PC_STEP         = 32'd4;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } fetch_entry_t;

    // Instructions are word aligned; the low two address bits are dropped.
    function automatic logic [INST_ADDR_W-1:0] align_pc(input logic [INST_ADDR_W-1:0] addr);
        return addr & ~INST_ADDR_W'(3);
    endfunction

endpackage

// File: rtl/if_queue_fifo.sv
// DEPTH-entry {pc, inst} FIFO with push/pop/flush and occupancy; head entry read from registers.
module if_queue_fifo
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  fetch_entry_t           i_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output fetch_entry_t           o_head,
    output logic [$clog2(DEPTH):0] o_occ,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;

    // Storage is cleared on reset so the head outputs read zero while the queue is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[PTR_W'(i)] <= '{pc: ZERO_WORD, inst: ZERO_WORD};
            end
        end else if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_occ   = r_occ;
    assign o_full  = (r_occ == OCC_W'(DEPTH));
    assign o_empty = (r_occ == '0);

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: PC, ROM fetch control, {pc, inst} queue and valid/ready hand-off to ID.
// Optional IF_FETCH_BYPASS_EN: empty-queue fetches go straight to ID with zero latency.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned             DEPTH    = 4,
    parameter logic [INST_ADDR_W-1:0]  RESET_PC = START_INST_ADDR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INST_W-1:0]      rom_inst,
    output logic [INST_ADDR_W-1:0] rom_addr,
    output logic                   rom_ce,
    input  logic                   redirect_i,
    input  logic [INST_ADDR_W-1:0] redirect_pc_i,
    input  logic                   id_ready_i,
    output logic                   id_valid_o,
    output logic [INST_W-1:0]      id_inst_o,
    output logic [INST_ADDR_W-1:0] id_pc_o,
    output logic [$clog2(DEPTH):0] occ_o
);

    logic [INST_ADDR_W-1:0] r_pc;
    fetch_entry_t           w_head;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_q_valid;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_fetch;

    if_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_push),
        .i_data  ('{pc: r_pc, inst: rom_inst}),
        .i_pop   (w_pop),
        .i_flush (redirect_i),
        .o_head  (w_head),
        .o_occ   (occ_o),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A redirect hides the head so the pop handshake cannot complete in the flush cycle.
    assign w_q_valid = ~w_empty & ~redirect_i;
    assign w_pop     = w_q_valid & id_ready_i;

    // A full queue may still fetch when the head leaves in the same cycle.
    assign w_fetch = rst & ~redirect_i & (~w_full | w_pop);
    assign rom_ce  = w_fetch ? CHIP_ENABLE : CHIP_DISABLE;
    assign rom_addr = r_pc;

`ifdef IF_FETCH_BYPASS_EN
    logic w_bypass;

    // Empty queue and a ready consumer: hand the fetched word to ID directly instead of queueing it.
    assign w_bypass   = rst & w_empty & ~redirect_i & id_ready_i;
    assign w_push     = w_fetch & ~w_bypass;
    assign id_valid_o = w_q_valid | w_bypass;
    assign id_inst_o  = w_bypass ? rom_inst : w_head.inst;
    assign id_pc_o    = w_bypass ? r_pc     : w_head.pc;
`else
    assign w_push     = w_fetch;
    assign id_valid_o = w_q_valid;
    assign id_inst_o  = w_head.inst;
    assign id_pc_o    = w_head.pc;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_i) begin
            r_pc <= align_pc(redirect_pc_i);
        end else if (w_fetch) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed, table-driven bench for if_fetch_queue with a word-indexed ROM model (inst = index * 0x11).
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rom_inst;
    logic [31:0] rom_addr;
    logic        rom_ce;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        id_ready_i = 1'b0;
    logic        id_valid_o;
    logic [31:0] id_inst_o;
    logic [31:0] id_pc_o;
    logic [2:0]  occ_o;

    int n_checks = 0;
    int n_errors = 0;

    if_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .rom_inst      (rom_inst),
        .rom_addr      (rom_addr),
        .rom_ce        (rom_ce),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .id_ready_i    (id_ready_i),
        .id_valid_o    (id_valid_o),
        .id_inst_o     (id_inst_o),
        .id_pc_o       (id_pc_o),
        .occ_o         (occ_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        logic [31:0] idx;
        idx = addr >> 2;
        return idx * 32'h11;
    endfunction

    assign rom_inst = rom_word(rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [2:0]  eocc;
        logic        ece;
        logic [31:0] eaddr;
    } vec_t;

    function automatic vec_t v(input logic redir, input logic [31:0] rpc, input logic rdy,
                               input logic ev, input logic [31:0] epc, input logic [2:0] eocc,
                               input logic ece, input logic [31:0] eaddr);
        vec_t r;
        r.redir = redir; r.rpc = rpc; r.rdy = rdy;
        r.ev = ev; r.epc = epc; r.eocc = eocc; r.ece = ece; r.eaddr = eaddr;
        return r;
    endfunction

    initial begin
        // Async reset assertion between edges, then reset-state checks.
        #1 rst = 1'b0;
        #1;
        chk("reset_rom_ce",   32'(rom_ce),     32'h0);
        chk("reset_rom_addr", rom_addr,        32'h0);
        chk("reset_valid",    32'(id_valid_o), 32'h0);
        chk("reset_inst",     id_inst_o,       32'h0);
        chk("reset_pc",       id_pc_o,         32'h0);
        chk("reset_occ",      32'(occ_o),      32'h0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        id_ready_i = 1'b1;
        rst = 1'b1;

`ifdef IF_FETCH_BYPASS_EN
        #1;
        chk("byp_valid",      32'(id_valid_o), 32'h1);
        chk("byp_pc_eq_addr", id_pc_o,         32'h0);
        chk("byp_addr",       rom_addr,        32'h0);
        chk("byp_inst",       id_inst_o,       rom_word(32'h0));
        chk("byp_occ0",       32'(occ_o),      32'h0);
        chk("byp_ce",         32'(rom_ce),     32'h1);
        next_cycle();
        #1;
        chk("byp_pc_next",    id_pc_o,         32'h4);
        chk("byp_addr_next",  rom_addr,        32'h4);
        chk("byp_inst_next",  id_inst_o,       rom_word(32'h4));
        chk("byp_occ_next",   32'(occ_o),      32'h0);
        id_ready_i = 1'b0;
        #1;
        chk("byp_stall_valid", 32'(id_valid_o), 32'h0);
        next_cycle();
        #1;
        chk("byp_stall_occ",  32'(occ_o),      32'h1);
        chk("byp_stall_pc",   id_pc_o,         32'h4);
`else
        begin
            vec_t vecs [22];
            vecs[0]  = v(0, 32'h0,        1, 0, 32'h0,        3'd0, 1, 32'h0);
            vecs[1]  = v(0, 32'h0,        1, 1, 32'h0,        3'd1, 1, 32'h4);
            vecs[2]  = v(0, 32'h0,        1, 1, 32'h4,        3'd1, 1, 32'h8);
            vecs[3]  = v(0, 32'h0,        1, 1, 32'h8,        3'd1, 1, 32'hC);
            vecs[4]  = v(0, 32'h0,        0, 1, 32'hC,        3'd1, 1, 32'h10);
            vecs[5]  = v(0, 32'h0,        0, 1, 32'hC,        3'd2, 1, 32'h14);
            vecs[6]  = v(0, 32'h0,        0, 1, 32'hC,        3'd3, 1, 32'h18);
            vecs[7]  = v(0, 32'h0,        0, 1, 32'hC,        3'd4, 0, 32'h1C);
            vecs[8]  = v(0, 32'h0,        0, 1, 32'hC,        3'd4, 0, 32'h1C);
            vecs[9]  = v(0, 32'h0,        1, 1, 32'hC,        3'd4, 1, 32'h1C);
            vecs[10] = v(0, 32'h0,        1, 1, 32'h10,       3'd4, 1, 32'h20);
            vecs[11] = v(0, 32'h0,        0, 1, 32'h14,       3'd4, 0, 32'h24);
            vecs[12] = v(1, 32'h103,      1, 0, 32'h0,        3'd4, 0, 32'h24);
            vecs[13] = v(0, 32'h0,        0, 0, 32'h0,        3'd0, 1, 32'h100);
            vecs[14] = v(0, 32'h0,        0, 1, 32'h100,      3'd1, 1, 32'h104);
            vecs[15] = v(0, 32'h0,        0, 1, 32'h100,      3'd2, 1, 32'h108);
            vecs[16] = v(1, 32'hFFFFFFFF, 0, 0, 32'h0,        3'd3, 0, 32'h10C);
            vecs[17] = v(1, 32'h200,      1, 0, 32'h0,        3'd0, 0, 32'hFFFFFFFC);
            vecs[18] = v(1, 32'hFFFFFFFE, 1, 0, 32'h0,        3'd0, 0, 32'h200);
            vecs[19] = v(0, 32'h0,        1, 0, 32'h0,        3'd0, 1, 32'hFFFFFFFC);
            vecs[20] = v(0, 32'h0,        1, 1, 32'hFFFFFFFC, 3'd1, 1, 32'h0);
            vecs[21] = v(0, 32'h0,        1, 1, 32'h0,        3'd1, 1, 32'h4);

            for (int i = 0; i < 22; i++) begin
                redirect_i    = vecs[i].redir;
                redirect_pc_i = vecs[i].rpc;
                id_ready_i    = vecs[i].rdy;
                #1;
                chk($sformatf("v%0d_valid", i), 32'(id_valid_o), 32'(vecs[i].ev));
                chk($sformatf("v%0d_occ", i),   32'(occ_o),      32'(vecs[i].eocc));
                chk($sformatf("v%0d_ce", i),    32'(rom_ce),     32'(vecs[i].ece));
                chk($sformatf("v%0d_addr", i),  rom_addr,        vecs[i].eaddr);
                if (vecs[i].ev) begin
                    chk($sformatf("v%0d_pc", i),   id_pc_o,   vecs[i].epc);
                    chk($sformatf("v%0d_inst", i), id_inst_o, rom_word(vecs[i].epc));
                end
                next_cycle();
            end
        end

        // Reset dropped mid-stream between edges with entries queued.
        redirect_i = 1'b0;
        id_ready_i = 1'b0;
        next_cycle();
        next_cycle();
        #1;
        chk("mid_occ_before", 32'(occ_o), 32'h3);
        rst = 1'b0;
        #1;
        chk("mid_rst_ce",    32'(rom_ce),     32'h0);
        chk("mid_rst_valid", 32'(id_valid_o), 32'h0);
        chk("mid_rst_occ",   32'(occ_o),      32'h0);
        chk("mid_rst_addr",  rom_addr,        32'h0);
        chk("mid_rst_pc",    id_pc_o,         32'h0);
        next_cycle();
        rst = 1'b1;
        id_ready_i = 1'b1;
        #1;
        chk("rel_addr",  rom_addr,        32'h0);
        chk("rel_ce",    32'(rom_ce),     32'h1);
        chk("rel_valid", 32'(id_valid_o), 32'h0);
        next_cycle();
        #1;
        chk("rel_first_valid", 32'(id_valid_o), 32'h1);
        chk("rel_first_pc",    id_pc_o,         32'h0);
        chk("rel_first_occ",   32'(occ_o),      32'h1);
        chk("rel_next_addr",   rom_addr,        32'h4);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
